// File: rtl/ror_arbiter_pkg.sv
// Shared constants and helpers for the round-robin rotate arbiter.
// Holds the rotator widths, the left-to-right amount conversion and the pointer step.
package ror_arbiter_pkg;

  localparam int ROR_W     = 16;
  localparam int ROR_AMT_W = 4;

  // A left rotate by n equals a right rotate by the 4-bit two's-complement of n.
  function automatic logic [ROR_AMT_W-1:0] ror_l2r_amt(input logic [ROR_AMT_W-1:0] amt);
    return (~amt) + 4'd1;
  endfunction

  function automatic int rr_next_ptr(input int cur, input int nreq);
    return (cur + 1 >= nreq) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/ror_arbiter_if.sv
// Request/response bundle between NREQ requesters, one consumer and the arbiter.
// req_dir exists only when ROR_DIR_EN is defined.
interface ror_arbiter_if
  import ror_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [ROR_W*NREQ-1:0]     req_data;
  logic [ROR_AMT_W*NREQ-1:0] req_amt;
`ifdef ROR_DIR_EN
  logic [NREQ-1:0]           req_dir;
`endif
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ROR_W-1:0]          rsp_data;
  logic [IDW-1:0]            rsp_id;

`ifdef ROR_DIR_EN
  modport master (
    output req_valid, req_data, req_amt, req_dir, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_dir, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
`else
  modport master (
    output req_valid, req_data, req_amt, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, req_amt, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
`endif

endinterface

// File: rtl/ror_arbiter_rot.sv
// Combinational 16-bit rotate-right; a log2 barrel of four conditional stages.
module ror_arbiter_rot
  import ror_arbiter_pkg::*;
(
  input  logic [ROR_W-1:0]     ror_in,
  input  logic [ROR_AMT_W-1:0] ror_val,
  output logic [ROR_W-1:0]     ror_out
);

  logic [ROR_W-1:0] w_stage [ROR_AMT_W+1];

  assign w_stage[0] = ror_in;

  // Stage gi rotates right by 2**gi when amount bit gi is set.
  for (genvar gi = 0; gi < ROR_AMT_W; gi++) begin : g_stage
    localparam int SH = 1 << gi;
    assign w_stage[gi+1] = ror_val[gi]
                           ? {w_stage[gi][SH-1:0], w_stage[gi][ROR_W-1:SH]}
                           : w_stage[gi];
  end

  assign ror_out = w_stage[ROR_AMT_W];

endmodule

// File: rtl/ror_arbiter.sv
// Round-robin arbiter sharing one rotate-right datapath among NREQ requesters,
// with a one-deep output register. Define ROR_DIR_EN to add per-requester left rotates.
module ror_arbiter
  import ror_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
)(
  input  logic           clk,
  input  logic           rst_n,
  ror_arbiter_if.slave   bus
);

  logic [ROR_W-1:0]     w_data_lane [NREQ];
  logic [ROR_AMT_W-1:0] w_amt_lane  [NREQ];

  logic                 w_found;
  logic [IDW-1:0]       w_winner;
  logic [ROR_W-1:0]     w_sel_data;
  logic [ROR_AMT_W-1:0] w_sel_amt;
  logic                 w_slot;
  logic                 w_hs;
  logic [NREQ-1:0]      w_ready;
  logic [ROR_W-1:0]     w_rot;

  logic                 r_rsp_valid;
  logic [ROR_W-1:0]     r_rsp_data;
  logic [IDW-1:0]       r_rsp_id;
  logic [IDW-1:0]       r_ptr;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign w_data_lane[gi] = bus.req_data[ROR_W*gi +: ROR_W];
`ifdef ROR_DIR_EN
    assign w_amt_lane[gi]  = bus.req_dir[gi]
                             ? ror_l2r_amt(bus.req_amt[ROR_AMT_W*gi +: ROR_AMT_W])
                             : bus.req_amt[ROR_AMT_W*gi +: ROR_AMT_W];
`else
    assign w_amt_lane[gi]  = bus.req_amt[ROR_AMT_W*gi +: ROR_AMT_W];
`endif
  end

  // Search from r_ptr upward with wrap; the inner loop keeps every lane index constant.
  always_comb begin
    int idx;
    idx        = 0;
    w_found    = 1'b0;
    w_winner   = '0;
    w_sel_data = '0;
    w_sel_amt  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      for (int j = 0; j < NREQ; j++) begin
        if (j == idx && !w_found && bus.req_valid[j]) begin
          w_found    = 1'b1;
          w_winner   = IDW'(j);
          w_sel_data = w_data_lane[j];
          w_sel_amt  = w_amt_lane[j];
        end
      end
    end
  end

  assign w_slot = !r_rsp_valid || bus.rsp_ready;
  assign w_hs   = rst_n && w_found && w_slot;

  always_comb begin
    w_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_hs && w_winner == IDW'(j)) begin
        w_ready[j] = 1'b1;
      end
    end
  end

  ror_arbiter_rot u_rot (
    .ror_in  (w_sel_data),
    .ror_val (w_sel_amt),
    .ror_out (w_rot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_ptr       <= '0;
    end else if (w_hs) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_rot;
      r_rsp_id    <= w_winner;
      r_ptr       <= IDW'(rr_next_ptr(int'(w_winner), NREQ));
    end else if (bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_ror_arbiter.sv
// Directed plus random bench for ror_arbiter with a response scoreboard.
// Build with ROR_DIR_EN defined to also exercise left rotates.
module tb_ror_arbiter;
  import ror_arbiter_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ror_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  ror_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [15:0]    data;
    logic [IDW-1:0] id;
  } rsp_t;

  rsp_t sb_q[$];
  int   m_ptr = 0;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [15:0] model_rot(input logic [15:0] w, input int amt, input bit left);
    logic [15:0] r;
    if (left) r = (w << amt) | (w >> (16 - amt));
    else      r = (w >> amt) | (w << (16 - amt));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] d, input logic [3:0] a, input bit l);
    bus.req_data[16*i +: 16] = d;
    bus.req_amt[4*i +: 4]    = a;
`ifdef ROR_DIR_EN
    bus.req_dir[i] = l;
`else
    if (l) $display("note: left rotate requested without ROR_DIR_EN");
`endif
  endtask

  // One clock: inputs already driven at the preceding negedge.
  task automatic step(input string tag);
    logic [NREQ-1:0] exp_ready;
    logic [15:0]     wdata;
    int              win, amt, idx;
    bit              slot, hs, m_valid, left, in_rst;
    rsp_t            e;
    #1;
    m_valid = sb_q.size() > 0;
    slot    = !m_valid || bus.rsp_ready;
    win     = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (win < 0 && bus.req_valid[idx]) win = idx;
    end
    hs = rst_n && (win >= 0) && slot;
    exp_ready = '0;
    wdata = '0; amt = 0; left = 0;
    if (hs) begin
      exp_ready[win] = 1'b1;
      wdata = bus.req_data[16*win +: 16];
      amt   = int'(bus.req_amt[4*win +: 4]);
`ifdef ROR_DIR_EN
      left  = bus.req_dir[win];
`endif
    end
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(exp_ready));
    in_rst = !rst_n;
    @(posedge clk);
    #1;
    if (in_rst) begin
      sb_q.delete();
      m_ptr = 0;
    end else begin
      if (m_valid && bus.rsp_ready) void'(sb_q.pop_front());
      if (hs) begin
        e.data = model_rot(wdata, amt, left);
        e.id   = IDW'(win);
        sb_q.push_back(e);
        m_ptr = (win + 1) % NREQ;
        $display("txn %s: req=%0d word=%h amt=%0d left=%0d -> %h", tag, win, wdata, amt, left, e.data);
      end
    end
    if (sb_q.size() > 0) begin
      chk({tag, ".valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, ".data"},  32'(bus.rsp_data),  32'(sb_q[0].data));
      chk({tag, ".id"},    32'(bus.rsp_id),    32'(sb_q[0].id));
    end else begin
      chk({tag, ".valid"}, 32'(bus.rsp_valid), 32'd0);
      if (in_rst) begin
        chk({tag, ".rst_data"}, 32'(bus.rsp_data), 32'd0);
        chk({tag, ".rst_id"},   32'(bus.rsp_id),   32'd0);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int exp_ids [4];
    exp_ids = '{1, 0, 1, 0};
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_amt   = '0;
    bus.rsp_ready = 1'b1;
`ifdef ROR_DIR_EN
    bus.req_dir   = '0;
`endif
    @(negedge clk);

    // Reset with every requester valid.
    rst_n = 1'b0;
    bus.req_valid = '1;
    step("rst0");
    step("rst1");

    // Release: requester 0 must win first.
    rst_n = 1'b1;
    set_req(0, 16'h1234, 4'd4, 1'b0);
    set_req(1, 16'hBEEF, 4'd8, 1'b0);
    step("first");
    chk("first.const_data", 32'(bus.rsp_data), 32'h4123);
    chk("first.const_id",   32'(bus.rsp_id),   32'd0);

    // Both valid, consumer always ready: grants alternate.
    for (int i = 0; i < 4; i++) begin
      set_req(0, 16'($urandom()), 4'($urandom_range(0, 15)), 1'b0);
      set_req(1, 16'($urandom()), 4'($urandom_range(0, 15)), 1'b0);
      step("alt");
      chk("alt.const_id", 32'(bus.rsp_id), 32'(exp_ids[i]));
    end

    // Stall three cycles while FULL, then release.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("stall");
    bus.rsp_ready = 1'b1;
    step("unstall");

    // Boundary amounts on requester 0 alone.
    bus.req_valid = 2'b01;
    set_req(0, 16'h8001, 4'd0, 1'b0);
    step("amt0");
    chk("amt0.const", 32'(bus.rsp_data), 32'h8001);
    set_req(0, 16'h8001, 4'd15, 1'b0);
    step("amt15");
    chk("amt15.const", 32'(bus.rsp_data), 32'h0003);
    set_req(0, 16'h0001, 4'd1, 1'b0);
    step("amt1");
    chk("amt1.const", 32'(bus.rsp_data), 32'h8000);

`ifdef ROR_DIR_EN
    set_req(0, 16'h1234, 4'd4, 1'b1);
    step("left4");
    chk("left4.const", 32'(bus.rsp_data), 32'h2341);
    set_req(0, 16'h1234, 4'd0, 1'b1);
    step("left0");
    chk("left0.const", 32'(bus.rsp_data), 32'h1234);
`endif

    // Idle cycle drains the register.
    bus.req_valid = '0;
    step("idle");

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      bus.req_valid = NREQ'($urandom_range(0, 3));
      bus.rsp_ready = 1'($urandom_range(0, 1));
      set_req(0, 16'($urandom()), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      set_req(1, 16'($urandom()), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
`ifndef ROR_DIR_EN
      set_req(0, bus.req_data[15:0], bus.req_amt[3:0], 1'b0);
      set_req(1, bus.req_data[31:16], bus.req_amt[7:4], 1'b0);
`endif
      step("rand");
    end

    // Reset while FULL discards the held result.
    bus.req_valid = 2'b10;
    bus.rsp_ready = 1'b1;
    step("fill");
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    step("rst_full");
    chk("rst_full.const_valid", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b11;
    step("post_rst");
    chk("post_rst.const_id", 32'(bus.rsp_id), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ror_arbiter.md
# ror_arbiter

Round-robin arbiter that shares one 16-bit rotate-right datapath among NREQ requesters in the beat-tracking pipeline. Each requester presents a 16-bit word and a 4-bit rotate amount over a valid/ready handshake. The block grants one requester per cycle, rotates the word through a single combinational rotator, and returns the result from an output register tagged with the requester index.

## Interface
- NREQ, 2: number of requesters; legal values are 2 to 4.
- IDW, 2: width of rsp_id; must satisfy 2^IDW >= NREQ.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_data  input  16*NREQ  word for requester i at [16i+15:16i].
- req_amt  input  4*NREQ  rotate amount for requester i at [4i+3:4i].
- req_dir  input  NREQ  direction: 0 = right, 1 = left. Present only with ROR_DIR_EN.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  16  rotated word.
- rsp_id  output  IDW  index of the requester that produced rsp_data.

## Operation
- The output register has two states, EMPTY and FULL, and the FSM is implemented as the rsp_valid flag.
- A slot is available when `slot = !rsp_valid || rsp_ready`.
- Arbitration: the winner is the first i with req_valid[i] set, searching from ptr upward and wrapping modulo NREQ.
- req_ready[winner] = slot. All other req_ready bits are 0.
- A handshake completes when req_valid[i] && req_ready[i].
- On a handshake:
  - rsp_data <= rotated word.
  - rsp_id <= winner.
  - rsp_valid <= 1.
  - ptr <= (winner + 1) mod NREQ.
- If rsp_ready is high and no handshake occurs, rsp_valid <= 0.
- If the register is FULL and rsp_ready is low, it holds rsp_data and rsp_id unchanged. ptr holds.
- If no requester is valid, ptr holds.
- A requester can be accepted every cycle while the consumer keeps rsp_ready high (full throughput).
- req_ready does not depend on req_valid of the same requester beyond the winner selection. Requesters must hold data stable while valid and not accepted.
- Rotation: the result is ror(word, amt), and amt = 0 passes the word through unchanged. amt is taken modulo 16 and is 4 bits, so there is no overflow.
- Reset (rst_n = 0 at a clock edge), including mid-transfer:
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, ptr = 0.
  - Any held result is discarded.
  - req_ready = 0 while rst_n is low.

## Timing
- Latency is 1 cycle: a handshake at edge N makes the result visible with rsp_valid = 1 after edge N.
- req_ready is combinational from req_valid, rsp_valid, rsp_ready and ptr.
- There are no combinational paths from req_data or req_amt to any output; only registered outputs carry data.
- Simultaneous drain and fill: when FULL with rsp_ready = 1 and a requester is valid, the new result replaces the old one in the same edge. rsp_valid stays 1.
- Fairness: a continuously valid requester waits at most NREQ-1 grants.

## Configuration
- ROR_DIR_EN defined:
  - The req_dir port exists.
  - A left rotate by n is performed as a right rotate by (16 - n) mod 16, i.e. the 4-bit two's-complement negation of amt.
  - Left by 0 equals the input word.
- ROR_DIR_EN undefined:
  - The req_dir port is absent.
  - All rotations are right rotations.
  - There is no negation logic.

## Structure
- The shared package holds:
  - ROR_W = 16 and ROR_AMT_W = 4.
  - A function computing the left-to-right amount conversion.
  - The round-robin next-pointer helper.
- One sub-module: the team's existing Rotator (ror_in, ror_val, ror_out), instantiated once and fed through the winner mux. The datapath is not duplicated.
- The arbiter, the pointer and the output register live in ror_arbiter itself.

## Test plan
- Reset with rst_n low for 2 cycles while req_valid = all ones gives rsp_valid = 0, rsp_data = 0 and req_ready = 0. After release, ptr = 0, so requester 0 is granted first.
- Requester 0 sends 0x1234, amt 4, with rsp_ready = 1. The next cycle shows rsp_data = 0x4123, rsp_id = 0, rsp_valid = 1.
- All NREQ = 2 requesters are held valid with rsp_ready = 1. Grants alternate 0, 1, 0, 1 with one result per cycle.
- Stall: rsp_ready = 0 for 3 cycles while FULL. rsp_data and rsp_id stay constant and req_ready = 0. On rsp_ready = 1 a new grant occurs in the same cycle.
- Boundary amounts (right rotate):
  - 0x8001 with amt 0 gives 0x8001.
  - 0x8001 with amt 15 gives 0x0003.
  - 0x0001 with amt 1 gives 0x8000.
- With ROR_DIR_EN: 0x1234 rotated left by amt 4 gives 0x2341, and left by 0 gives 0x1234. rst_n asserted while FULL clears rsp_valid on the next edge.
